toggle_hs_receiver: RTL and testbench
=====================================

Name: toggle_hs_receiver

Overview:
- Receiving end of a two-phase (toggle) bundled-data handshake.
- The sender flips `req_tgl` (T-flip-flop style) with `req_data` held stable. This block synchronises `req_tgl`, detects the toggle, captures the data, and presents it on a valid/ready output port.
- It then toggles `ack_tgl` back to the sender.
- It also keeps an event count and a sticky protocol-error flag.

Parameters:
- DW, 8, data width of `req_data` / `out_data`.
- CW, 8, event counter width.
- SYNC_STAGES, 2, flip-flop stages on `req_tgl` (minimum 2).

Ports:
- clk       input   1    rising-edge clock
- rst       input   1    asynchronous, active-high reset
- req_tgl   input   1    request toggle from sender; each level change is one transfer
- req_data  input   DW   bundled data, stable from the `req_tgl` change until `ack_tgl` changes
- ack_tgl   output  1    acknowledge toggle back to sender
- out_valid output  1    captured word available
- out_data  output  DW   captured word
- out_ready input   1    downstream accepts the word when high together with `out_valid`
- evt_cnt   output  CW   number of transfers captured, wraps modulo 2^CW
- busy      output  1    high whenever the FSM is not in IDLE
- proto_err output  1    sticky: sender toggled again before `ack_tgl` was returned

Behaviour:
- Reset (asynchronous, while `rst`=1):
  - sync chain, `req_seen`, `ack_tgl`, `out_valid`, `out_data`, `evt_cnt` and `proto_err` all 0.
  - FSM in IDLE.
- Reset mid-transfer discards the pending word and returns `ack_tgl` to 0. The sender must be reset in the same domain.
- Synchroniser: `req_sync` is the last stage of the SYNC_STAGES chain.
- `req_seen` records the `req_sync` level of the last captured transfer.
- FSM IDLE:
  - If `req_sync != req_seen`: `out_data` <= `req_data`, `out_valid` <= 1, `req_seen` <= `req_sync`, `evt_cnt` <= `evt_cnt` + 1, go to HOLD.
  - Otherwise stay in IDLE.
- FSM HOLD:
  - `out_valid` held at 1 and `out_data` held stable.
  - On an edge with `out_ready`=1: `out_valid` <= 0, go to ACK.
- FSM ACK: `ack_tgl` <= ~`ack_tgl`, go to IDLE. ACK is exactly one cycle.
- Latency:
  - Toggle sampled at edge E0 → `out_valid` rises after edge E0 + SYNC_STAGES (3rd edge when SYNC_STAGES=2).
  - Handshake at edge H → `ack_tgl` flips after edge H+1.
  - The next toggle can be captured no earlier than edge H+2 + SYNC_STAGES.
- `out_ready` high in IDLE or ACK has no effect. `out_ready` held permanently high gives a one-cycle `out_valid` pulse.
- `evt_cnt` increments only on capture and wraps from 2^CW-1 to 0 with no flag.
- Protocol error:
  - In HOLD or ACK, `req_sync != req_seen` sets `proto_err`. It stays set until reset.
  - The captured word is unaffected.
  - If `req_sync` still differs from `req_seen` on return to IDLE, it is captured as a new transfer.
  - A double toggle that restores the original level is not detected.
- `busy` = (state != IDLE), decoded combinationally from the state register.
- All outputs are registered, except `busy`.

Decomposition:
- Shared include `tgl_hs_defs.vh`:
  - localparams for state encoding: IDLE=2'd0, HOLD=2'd1, ACK=2'd2. Code 2'd3 is illegal and recovers to IDLE.
  - SYNC_STAGES default.
- One sub-module: `sync_chain` (parameter STAGES, input `d`, output `q`, same clk/rst). This is reused by the matching transmitter for its `ack_tgl` input.

Test Plan:
- Reset: `rst`=1 at t=0 with inputs random, release at t=23 → `ack_tgl`=0, `out_valid`=0, `evt_cnt`=0, `proto_err`=0, `busy`=0.
- Single transfer: `req_data`=8'hA5, `req_tgl` 0→1, `out_ready`=1 → `out_valid` high for exactly 1 cycle, 3 edges after the toggle, with `out_data`=8'hA5. `ack_tgl`=1 one edge after the handshake. `evt_cnt`=1.
- Backpressure: `out_ready`=0 for 10 cycles after capture of 8'h3C → `out_valid` and `out_data`=8'h3C held, `busy`=1, `ack_tgl` unchanged. Raising `out_ready` completes the transfer and `ack_tgl` flips.
- Back-to-back: sender model issuing 300 transfers (data = index[7:0]), each toggle only after `ack_tgl` changes → all words in order, `evt_cnt` wraps to 300 mod 256 = 44, `proto_err`=0.
- Protocol violation: second `req_tgl` flip while in HOLD with 8'h11 pending → `proto_err`=1 and sticky. 8'h11 is delivered intact, then the second word is captured after ACK.
- Async reset mid-HOLD: assert `rst` between clock edges → `out_valid`, `ack_tgl` and `evt_cnt` go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/toggle_hs_receiver_pkg.sv
// Shared definitions for the toggle-handshake receiver: FSM encoding,
// default synchroniser depth and a small toggle-detect helper.
package toggle_hs_receiver_pkg;

  localparam int SYNC_STAGES_DEF = 2;

  // Code 2'd3 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // A transfer is pending whenever the synchronised request level differs
  // from the level recorded at the last capture.
  function automatic logic tgl_pending(input logic req_sync, input logic req_seen);
    return req_sync ^ req_seen;
  endfunction

endpackage

// File: rtl/toggle_hs_receiver_sync_chain.sv
// Multi-flop level synchroniser. Shared with the matching transmitter,
// which uses it on its ack_tgl input.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous level through the chain; stage 0 takes the raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/toggle_hs_receiver.sv
// Receiving end of a two-phase bundled-data handshake: synchronises req_tgl,
// captures req_data on each level change, offers it on a valid/ready port and
// returns ack_tgl. Also counts transfers and flags early re-toggles.
import toggle_hs_receiver_pkg::*;

module toggle_hs_receiver #(
  parameter int DW          = 8,
  parameter int CW          = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_tgl,
  input  logic [DW-1:0] req_data,
  output logic          ack_tgl,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] evt_cnt,
  output logic          busy,
  output logic          proto_err
);

  logic          w_req_sync;
  logic          w_pending;

  state_t        r_state,    w_state_nxt;
  logic          r_req_seen, w_req_seen_nxt;
  logic          r_ack,      w_ack_nxt;
  logic          r_valid,    w_valid_nxt;
  logic [DW-1:0] r_data,     w_data_nxt;
  logic [CW-1:0] r_cnt,      w_cnt_nxt;
  logic          r_err,      w_err_nxt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_tgl),
    .q   (w_req_sync)
  );

  assign w_pending = tgl_pending(w_req_sync, r_req_seen);

  // Next-state and next-output decode; every register holds unless its state acts.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_seen_nxt = r_req_seen;
    w_ack_nxt      = r_ack;
    w_valid_nxt    = r_valid;
    w_data_nxt     = r_data;
    w_cnt_nxt      = r_cnt;
    w_err_nxt      = r_err;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          w_data_nxt     = req_data;
          w_valid_nxt    = 1'b1;
          w_req_seen_nxt = w_req_sync;
          w_cnt_nxt      = r_cnt + {{(CW-1){1'b0}}, 1'b1};
          w_state_nxt    = ST_HOLD;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // A new toggle before ack is returned is an error; the held word is kept.
        w_err_nxt = r_err | w_pending;
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_ACK: begin
        w_err_nxt   = r_err | w_pending;
        w_ack_nxt   = ~r_ack;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any pending word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_req_seen <= 1'b0;
      r_ack      <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_seen <= w_req_seen_nxt;
      r_ack      <= w_ack_nxt;
      r_valid    <= w_valid_nxt;
      r_data     <= w_data_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign ack_tgl   = r_ack;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign evt_cnt   = r_cnt;
  assign proto_err = r_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_toggle_hs_receiver.sv
// Directed bench for toggle_hs_receiver: table of transfers plus hand-written
// sequences for latency, backpressure, async reset, wrap and protocol error.
module tb_toggle_hs_receiver;

  logic       clk;
  logic       rst;
  logic       req_tgl;
  logic [7:0] req_data;
  logic       ack_tgl;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [7:0] evt_cnt;
  logic       busy;
  logic       proto_err;

  int n_checks;
  int n_fail;
  logic tb_tgl;

  typedef struct {
    logic [7:0] data;
    int         wait_cyc;
    logic [7:0] exp_cnt;
    logic       exp_ack;
  } vec_t;

  vec_t vecs [5];

  toggle_hs_receiver #(
    .DW (8), .CW (8), .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_tgl   (req_tgl),
    .req_data  (req_data),
    .ack_tgl   (ack_tgl),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .evt_cnt   (evt_cnt),
    .busy      (busy),
    .proto_err (proto_err)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_toggle(input logic [7:0] data);
    req_data = data;
    tb_tgl   = ~tb_tgl;
    req_tgl  = tb_tgl;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_ack(input string name, input logic prev);
    int k;
    k = 0;
    while (ack_tgl === prev && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, ack_tgl}, {31'd0, ~prev});
  endtask

  initial begin
    logic prev_ack;
    n_checks  = 0;
    n_fail    = 0;
    tb_tgl    = 1'b0;

    vecs[0] = '{data: 8'h00, wait_cyc: 0, exp_cnt: 8'd3, exp_ack: 1'b1};
    vecs[1] = '{data: 8'hFF, wait_cyc: 1, exp_cnt: 8'd4, exp_ack: 1'b0};
    vecs[2] = '{data: 8'h55, wait_cyc: 3, exp_cnt: 8'd5, exp_ack: 1'b1};
    vecs[3] = '{data: 8'hAA, wait_cyc: 0, exp_cnt: 8'd6, exp_ack: 1'b0};
    vecs[4] = '{data: 8'h81, wait_cyc: 2, exp_cnt: 8'd7, exp_ack: 1'b1};

    // Reset with random inputs, released off-edge at t=23.
    rst       = 1'b1;
    req_tgl   = 1'b0;
    req_data  = 8'($urandom);
    out_ready = 1'($urandom);
    #23;
    rst       = 1'b0;
    req_data  = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_ack",   {31'd0, ack_tgl},   32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_cnt",   {24'd0, evt_cnt},   32'd0);
    check("rst_err",   {31'd0, proto_err}, 32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);

    // Single transfer, ready held high: valid after the 3rd edge, for one cycle.
    out_ready = 1'b1;
    send_toggle(8'hA5);
    @(negedge clk);
    check("single_e0_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("single_e1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("single_e2_valid", {31'd0, out_valid}, 32'd1);
    check("single_data",     {24'd0, out_data},  32'h0000_00A5);
    check("single_busy",     {31'd0, busy},      32'd1);
    @(negedge clk);
    check("single_pulse_end", {31'd0, out_valid}, 32'd0);
    check("single_ack_early", {31'd0, ack_tgl},   32'd0);
    @(negedge clk);
    check("single_ack", {31'd0, ack_tgl}, 32'd1);
    check("single_cnt", {24'd0, evt_cnt}, 32'd1);
    check("single_idle", {31'd0, busy},   32'd0);
    out_ready = 1'b0;

    // Backpressure: word 3C held for 10 cycles with ready low.
    send_toggle(8'h3C);
    wait_valid("bp_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data",  {24'd0, out_data},  32'h0000_003C);
      check("bp_hold_busy",  {31'd0, busy},      32'd1);
      check("bp_hold_ack",   {31'd0, ack_tgl},   32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_ack", {31'd0, ack_tgl}, 32'd0);
    check("bp_cnt", {24'd0, evt_cnt}, 32'd2);

    // Table-driven transfers with varying ready delays.
    for (int v = 0; v < 5; v++) begin
      send_toggle(vecs[v].data);
      wait_valid("tbl_valid_timeout");
      check("tbl_data", {24'd0, out_data}, {24'd0, vecs[v].data});
      for (int w = 0; w < vecs[v].wait_cyc; w++) begin
        @(negedge clk);
        check("tbl_wait_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("tbl_hs_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;
      @(negedge clk);
      check("tbl_ack",  {31'd0, ack_tgl}, {31'd0, vecs[v].exp_ack});
      check("tbl_cnt",  {24'd0, evt_cnt}, {24'd0, vecs[v].exp_cnt});
      check("tbl_busy", {31'd0, busy},    32'd0);
    end

    // Async reset while a word is held: outputs clear before any clock edge.
    send_toggle(8'h5A);
    wait_valid("ar_valid_timeout");
    check("ar_pre_ack", {31'd0, ack_tgl}, 32'd1);
    check("ar_pre_cnt", {24'd0, evt_cnt}, 32'd8);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_ack",   {31'd0, ack_tgl},   32'd0);
    check("ar_cnt",   {24'd0, evt_cnt},   32'd0);
    check("ar_busy",  {31'd0, busy},      32'd0);
    tb_tgl  = 1'b0;
    req_tgl = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: 300 transfers, each toggle only after ack returns.
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      d = 8'(i);
      prev_ack = ack_tgl;
      send_toggle(d);
      wait_valid("b2b_valid_timeout");
      check("b2b_data", {24'd0, out_data}, {24'd0, d});
      wait_ack("b2b_ack_timeout", prev_ack);
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("b2b_cnt_wrap", {24'd0, evt_cnt},   32'd44);
    check("b2b_err",      {31'd0, proto_err}, 32'd0);
    check("b2b_ack",      {31'd0, ack_tgl},   32'd0);

    // Protocol violation: second toggle while 11 is held.
    send_toggle(8'h11);
    wait_valid("pe_valid_timeout");
    check("pe_pre_err", {31'd0, proto_err}, 32'd0);
    send_toggle(8'h22);
    repeat (4) @(negedge clk);
    check("pe_err",        {31'd0, proto_err}, 32'd1);
    check("pe_held_valid", {31'd0, out_valid}, 32'd1);
    check("pe_held_data",  {24'd0, out_data},  32'h0000_0011);
    out_ready = 1'b1;
    @(negedge clk);
    check("pe_hs_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    check("pe_ack", {31'd0, ack_tgl}, 32'd1);
    @(negedge clk);
    check("pe_second_valid", {31'd0, out_valid}, 32'd1);
    check("pe_second_data",  {24'd0, out_data},  32'h0000_0022);
    check("pe_cnt",          {24'd0, evt_cnt},   32'd46);
    out_ready = 1'b1;
    wait_ack("pe_ack2_timeout", 1'b1);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("pe_sticky", {31'd0, proto_err}, 32'd1);
    check("pe_idle",   {31'd0, busy},      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
